// File: rtl/field_counter.sv
// Settable modulo-MODULUS time field: running time value, alarm value, step/auto-repeat
// editing, carry to the next field and a one-cycle alarm-hit pulse.
module field_counter #(
  parameter int MODULUS       = 24,
  parameter int WIDTH         = 8,
  parameter int FIELD_SEL     = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cnt_en,
  input  logic [1:0]       time_clock_key,
  input  logic [2:0]       mode_key,
  input  logic [2:0]       add_key,
  input  logic             alarm_en,
  output logic [WIDTH-1:0] time_val,
  output logic [WIDTH-1:0] alarm_val,
  output logic             carry_out,
  output logic             alarm_hit
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODV      = (WIDTH+1)'(MODULUS);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} rep_state_t;

  rep_state_t    state;
  logic [CW-1:0] rep_cnt;
  logic          key_q;

  logic             edit, tgt_alarm, key_rise, rep_req;
  logic             inc_req, dec_req, rpt_req;
  logic [WIDTH-1:0] time_nxt, alarm_nxt;
  logic             carry_nxt, hit_nxt;
  logic             unused_key;

  assign unused_key = time_clock_key[0];

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    return (v >= MAXV) ? '0 : v + 1'b1;
  endfunction

  // Out-of-range values decrement to the top of the range rather than to v-1.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
    return (v == '0 || {1'b0, v} >= MODV) ? MAXV : v - 1'b1;
  endfunction

  assign edit      = mode_key[FIELD_SEL];
  assign tgt_alarm = time_clock_key[1];
  assign key_rise  = add_key[2] & ~key_q;

  always_comb begin
    rep_req = 1'b0;
    if (edit && add_key[2]) begin
      case (state)
        S_IDLE:   rep_req = key_rise;
        S_HOLD:   rep_req = (rep_cnt == HOLD_LAST);
        S_REPEAT: rep_req = (rep_cnt == REP_LAST);
        default:  rep_req = 1'b0;
      endcase
    end
  end

  // Explicit keys win; a repeat step that collides with them is simply dropped.
  assign inc_req = edit & add_key[0];
  assign dec_req = edit & ~add_key[0] & add_key[1];
  assign rpt_req = edit & ~add_key[0] & ~add_key[1] & rep_req;

  always_comb begin
    time_nxt  = time_val;
    alarm_nxt = alarm_val;
    carry_nxt = 1'b0;
    hit_nxt   = 1'b0;
    if (edit && !tgt_alarm) begin
      if (inc_req || rpt_req) time_nxt = step_up(time_val);
      else if (dec_req)       time_nxt = step_dn(time_val);
    end else if (cnt_en) begin
      time_nxt  = step_up(time_val);
      carry_nxt = (time_val >= MAXV);
      hit_nxt   = alarm_en && (time_nxt == alarm_val);
    end
    if (edit && tgt_alarm) begin
      if (inc_req || rpt_req) alarm_nxt = step_up(alarm_val);
      else if (dec_req)       alarm_nxt = step_dn(alarm_val);
    end
  end

  // key_q resets high so a key held through reset must be released before it steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rep_cnt   <= '0;
      key_q     <= 1'b1;
      time_val  <= '0;
      alarm_val <= '0;
      carry_out <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      key_q     <= add_key[2];
      time_val  <= time_nxt;
      alarm_val <= alarm_nxt;
      carry_out <= carry_nxt;
      alarm_hit <= hit_nxt;
      if (!edit || !add_key[2]) begin
        state   <= S_IDLE;
        rep_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: if (key_rise) begin
            state   <= S_HOLD;
            rep_cnt <= '0;
          end
          S_HOLD: if (rep_cnt == HOLD_LAST) begin
            state   <= S_REPEAT;
            rep_cnt <= '0;
          end else rep_cnt <= rep_cnt + 1'b1;
          S_REPEAT: if (rep_cnt == REP_LAST) rep_cnt <= '0;
                    else rep_cnt <= rep_cnt + 1'b1;
          default: begin
            state   <= S_IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_field_counter.sv
// Directed bench for field_counter with default parameters (MODULUS 24, FIELD_SEL 2,
// HOLD 16, REPEAT 4); expected values are hand-derived.
module tb_field_counter;
  logic       clk = 0;
  logic       reset_n;
  logic       cnt_en;
  logic [1:0] time_clock_key;
  logic [2:0] mode_key;
  logic [2:0] add_key;
  logic       alarm_en;
  logic [7:0] time_val, alarm_val;
  logic       carry_out, alarm_hit;

  int checks = 0;
  int errors = 0;

  field_counter dut (
    .clk(clk), .reset_n(reset_n), .cnt_en(cnt_en), .time_clock_key(time_clock_key),
    .mode_key(mode_key), .add_key(add_key), .alarm_en(alarm_en),
    .time_val(time_val), .alarm_val(alarm_val), .carry_out(carry_out), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cnt_en = 0; time_clock_key = 2'b00; mode_key = 3'b000; add_key = 3'b000; alarm_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    checks++;
    if (time_val !== 8'd0 || alarm_val !== 8'd0 || carry_out !== 1'b0 || alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset: time=%0d alarm=%0d carry=%b hit=%b want all 0",
               time_val, alarm_val, carry_out, alarm_hit);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_count_wrap();
    int expv;
    cnt_en = 1;
    for (int i = 0; i < 24; i++) begin
      tick();
      expv = (i + 1) % 24;
      checks++;
      if (time_val !== 8'(expv) || carry_out !== (i == 23) || alarm_hit !== 1'b0) begin
        errors++;
        $display("FAIL count[%0d]: time=%0d carry=%b hit=%b want time=%0d carry=%b hit=0",
                 i, time_val, carry_out, alarm_hit, expv, (i == 23));
      end
    end
    cnt_en = 0;
    tick();
    checks++;
    if (carry_out !== 1'b0 || time_val !== 8'd0) begin
      errors++;
      $display("FAIL count_idle: time=%0d carry=%b want 0/0", time_val, carry_out);
    end
  endtask

  task automatic test_edit_time();
    mode_key = 3'b100; time_clock_key = 2'b00;
    add_key = 3'b010;
    tick();
    checks++;
    if (time_val !== 8'd23 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL edit_dec: time=%0d carry=%b want 23/0", time_val, carry_out);
    end
    add_key = 3'b001;
    tick();
    checks++;
    if (time_val !== 8'd0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL edit_inc_wrap: time=%0d carry=%b want 0/0", time_val, carry_out);
    end
    add_key = 3'b000; cnt_en = 1;
    tick();
    checks++;
    if (time_val !== 8'd0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL edit_cnt_ignored: time=%0d carry=%b want 0/0", time_val, carry_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_alarm();
    mode_key = 3'b100; time_clock_key = 2'b10; add_key = 3'b001;
    repeat (5) tick();
    idle_inputs();
    tick();
    checks++;
    if (alarm_val !== 8'd5 || time_val !== 8'd0) begin
      errors++;
      $display("FAIL alarm_set: alarm=%0d time=%0d want 5/0", alarm_val, time_val);
    end
    alarm_en = 1; cnt_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (alarm_hit !== (i == 4) || time_val !== 8'(i + 1)) begin
        errors++;
        $display("FAIL alarm_hit[%0d]: hit=%b time=%0d want hit=%b time=%0d",
                 i, alarm_hit, time_val, (i == 4), i + 1);
      end
    end
    cnt_en = 0;
    tick();
    checks++;
    if (alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL alarm_one_cycle: hit=%b want 0", alarm_hit);
    end
    alarm_en = 0; cnt_en = 1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (alarm_hit !== 1'b0) begin
        errors++;
        $display("FAIL alarm_disabled[%0d]: hit=%b want 0", i, alarm_hit);
      end
    end
    cnt_en = 0; alarm_en = 1; mode_key = 3'b100; time_clock_key = 2'b00;
    add_key = 3'b010;
    tick();
    add_key = 3'b001;
    tick();
    checks++;
    if (time_val !== 8'd5 || alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL alarm_step_no_hit: time=%0d hit=%b want 5/0", time_val, alarm_hit);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_repeat();
    int expv;
    do_reset();
    mode_key = 3'b100; add_key = 3'b100;
    expv = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 0 || (k >= 16 && (k - 16) % 4 == 0)) expv++;
      checks++;
      if (time_val !== 8'(expv) || carry_out !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: time=%0d carry=%b want %0d/0", k, time_val, carry_out, expv);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (time_val !== 8'd5) begin
      errors++;
      $display("FAIL hold_final: time=%0d want 5", time_val);
    end
  endtask

  task automatic test_priority_parallel();
    do_reset();
    mode_key = 3'b100; add_key = 3'b011;
    tick();
    checks++;
    if (time_val !== 8'd1) begin
      errors++;
      $display("FAIL prio_both: time=%0d want 1", time_val);
    end
    add_key = 3'b010;
    repeat (2) tick();
    checks++;
    if (time_val !== 8'd23) begin
      errors++;
      $display("FAIL prio_dec2: time=%0d want 23", time_val);
    end
    time_clock_key = 2'b10; add_key = 3'b001; cnt_en = 1;
    tick();
    checks++;
    if (time_val !== 8'd0 || carry_out !== 1'b1 || alarm_val !== 8'd1 || alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL parallel: time=%0d carry=%b alarm=%0d hit=%b want 0/1/1/0",
               time_val, carry_out, alarm_val, alarm_hit);
    end
    idle_inputs();
    tick();
    checks++;
    if (carry_out !== 1'b0) begin
      errors++;
      $display("FAIL parallel_carry_pulse: carry=%b want 0", carry_out);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    mode_key = 3'b100; add_key = 3'b100;
    repeat (19) tick();
    checks++;
    if (time_val !== 8'd2) begin
      errors++;
      $display("FAIL midhold_pre: time=%0d want 2", time_val);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if (time_val !== 8'd0 || alarm_val !== 8'd0 || carry_out !== 1'b0 || alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL midhold_reset: time=%0d alarm=%0d carry=%b hit=%b want all 0",
               time_val, alarm_val, carry_out, alarm_hit);
    end
    tick();
    reset_n = 1;
    repeat (20) tick();
    checks++;
    if (time_val !== 8'd0) begin
      errors++;
      $display("FAIL midhold_no_step: time=%0d want 0", time_val);
    end
    add_key = 3'b000;
    tick();
    add_key = 3'b100;
    tick();
    checks++;
    if (time_val !== 8'd1) begin
      errors++;
      $display("FAIL midhold_new_edge: time=%0d want 1", time_val);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_count_wrap();
    test_edit_time();
    test_alarm();
    test_hold_repeat();
    test_priority_parallel();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_counter.md
# field_counter

Parametrised, settable modulo-N time-field counter; the generalised successor of the fixed-range hour/minute/second field blocks in the clock datapath. Holds one running time value and one alarm value. Both values can be edited with increment/decrement keys, including a held-key auto-repeat. Emits a carry pulse to the next field and a one-cycle alarm-hit pulse; one instance per field (sec/min/hour), chained by carry.

## Interface
- MODULUS, 24: field counts 0..MODULUS-1; legal 2..2^WIDTH
- WIDTH, 8: width of value registers
- FIELD_SEL, 2: index of mode_key bit that selects this field for editing
- HOLD_CYCLES, 16: cycles add_key[2] must be held before auto-repeat starts; ≥1
- REPEAT_CYCLES, 4: cycles between auto-repeat steps; ≥1

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cnt_en  in  1  count tick (carry from lower field / 1 Hz strobe), one cycle wide
- time_clock_key  in  2  [1]=1 edits alarm value, else edits time value; [0] unused
- mode_key  in  3  one-hot field select; this field editable when mode_key[FIELD_SEL]=1
- add_key  in  3  [0] increment step, [1] decrement step, [2] held increment with auto-repeat
- alarm_en  in  1  enables alarm_hit generation
- time_val  out  WIDTH  running time value
- alarm_val  out  WIDTH  alarm value
- carry_out  out  1  one-cycle pulse, time_val wrapped by cnt_en
- alarm_hit  out  1  one-cycle pulse, time_val reached alarm_val by counting

## Operation
- edit = mode_key[FIELD_SEL]; target = alarm if time_clock_key[1] else time.
- Step request per cycle, priority add_key[0] > add_key[1] > repeat step from add_key[2]; at most one step per cycle.
- Increment: v ≥ MODULUS-1 → 0, else v+1. Decrement: v = 0 or v ≥ MODULUS → MODULUS-1, else v-1. Steps never generate carry_out.
- Time counting: when cnt_en=1 and not (edit and target=time): time_val ≥ MODULUS-1 → 0 with carry_out=1, else +1. While editing time, cnt_en ignored (tick lost, no carry).
- Alarm editing leaves counting unaffected; time and alarm update independently in same cycle.
- alarm_hit: registered 1 when a cnt_en count (not a step) makes next time_val == alarm_val and alarm_en=1.
- Auto-repeat FSM on add_key[2] (only while edit=1): IDLE → (key rises) step, go HOLD, clear cnt; HOLD: cnt counts; at cnt = HOLD_CYCLES-1 step, go REPEAT, clear cnt; REPEAT: step every REPEAT_CYCLES cycles; key low or edit low → IDLE, counter cleared. A step suppressed by add_key[0]/[1] priority is lost, timer continues.
- Arithmetic in WIDTH bits; repeat counter sized clog2(max(HOLD_CYCLES, REPEAT_CYCLES))+1.

## Timing
- Reset: time_val=0, alarm_val=0, carry_out=0, alarm_hit=0, FSM IDLE, repeat counter 0.
- All outputs registered; value changes visible one cycle after the qualifying input edge.
- carry_out and alarm_hit high exactly one cycle, same cycle as the updated time_val.
- Held add_key[2]: steps at cycles 0, HOLD_CYCLES, HOLD_CYCLES+REPEAT_CYCLES, … after the rising edge.
- add_key[0]/[1] held N cycles → N steps (no edge detection).
- Reset mid-hold: FSM IDLE; key still high after release of reset counts as new rising edge only after it is seen low first.

## Test plan
- MODULUS=24: 24 cnt_en pulses from reset → time_val 1..23,0; carry_out one pulse with time_val=0; no other carries.
- edit, target time, time_val=0, add_key[1] one cycle → 23, no carry; then add_key[0] one cycle → 0, no carry; cnt_en during edit → no change.
- alarm edit to 5 (time_clock_key[1]=1, five add_key[0] cycles) with alarm_en=1, time counting from 0 → single alarm_hit as time_val becomes 5; alarm_en=0 → none; stepping time to 5 → none.
- HOLD_CYCLES=16, REPEAT_CYCLES=4, add_key[2] held 30 cycles from 0 → steps at 0,16,20,24,28 → time_val=5.
- add_key[0] and add_key[1] both high one cycle → +1 only; cnt_en with time_val=23 while editing alarm → time 0, carry_out=1, alarm updates in parallel.
- reset_n low during REPEAT with add_key[2] held → all outputs 0; after reset, no step until key goes low then high.
